// File: rtl/riscv_mc_cpu.sv
// Multi-cycle RV32I/RV32E core with one unified valid/ready memory port.
// Each instruction is sequenced through fetch/decode/exec/mem/writeback; illegal or misaligned operations halt the core.
module riscv_mc_cpu #(
  parameter logic [31:0] RESET_PC         = 32'h0000_0000,
  parameter int          NREGS            = 32,
  parameter bit          TRAP_ON_MISALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_valid,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] PC,
  output logic [31:0] Result,
  output logic        retire,
  output logic        halted
);
  localparam int RW = $clog2(NREGS);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;

  state_t      state_q;
  logic [31:0] pc_q, ir_q, a_q, b_q, alu_q, mdr_q, result_q;
  logic        retire_q;
  logic [31:0] rf_q [NREGS];

  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, op2, alu_d, tgt_d, addr_d, wb_val;
  logic [31:0] rs1_val, rs2_val;
  logic        legal, use_rs1, use_rs2, use_rd, reg_bad, br_taken, is_jump;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign f3     = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign f7     = ir_q[31:25];

  assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_u = {ir_q[31:12], 12'b0};
  assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

  assign rs1_val = (rs1 == '0) ? '0 : rf_q[rs1[RW-1:0]];
  assign rs2_val = (rs2 == '0) ? '0 : rf_q[rs2[RW-1:0]];

  always_comb begin
    legal   = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    case (opcode)
      OP_R: begin
        legal = (f7 == 7'b0000000) || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
        {use_rs1, use_rs2, use_rd} = 3'b111;
      end
      OP_I: begin
        if (f3 == 3'b001)      legal = (f7 == 7'b0000000);
        else if (f3 == 3'b101) legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
        else                   legal = 1'b1;
        {use_rs1, use_rd} = 2'b11;
      end
      OP_LUI, OP_AUIPC, OP_JAL: begin
        legal  = 1'b1;
        use_rd = 1'b1;
      end
      OP_BR: begin
        legal = (f3 != 3'b010) && (f3 != 3'b011);
        {use_rs1, use_rs2} = 2'b11;
      end
      OP_JALR: begin
        legal = (f3 == 3'b000);
        {use_rs1, use_rd} = 2'b11;
      end
      OP_LD: begin
        legal = (f3 == 3'b010);
        {use_rs1, use_rd} = 2'b11;
      end
      OP_ST: begin
        legal = (f3 == 3'b010);
        {use_rs1, use_rs2} = 2'b11;
      end
      default: legal = 1'b0;
    endcase
    reg_bad = (use_rs1 && int'(rs1) >= NREGS) || (use_rs2 && int'(rs2) >= NREGS) ||
              (use_rd && int'(rd) >= NREGS);
  end

  always_comb begin
    op2 = (opcode == OP_R) ? b_q : imm_i;
    case (f3)
      3'b000:  alu_d = (opcode == OP_R && ir_q[30]) ? a_q - op2 : a_q + op2;
      3'b001:  alu_d = a_q << op2[4:0];
      3'b010:  alu_d = {31'b0, $signed(a_q) < $signed(op2)};
      3'b011:  alu_d = {31'b0, a_q < op2};
      3'b100:  alu_d = a_q ^ op2;
      3'b101:  alu_d = ir_q[30] ? $unsigned($signed(a_q) >>> op2[4:0]) : a_q >> op2[4:0];
      3'b110:  alu_d = a_q | op2;
      default: alu_d = a_q & op2;
    endcase
    if (opcode == OP_LUI)   alu_d = imm_u;
    if (opcode == OP_AUIPC) alu_d = pc_q + imm_u;

    case (f3)
      3'b000:  br_taken = (a_q == b_q);
      3'b001:  br_taken = (a_q != b_q);
      3'b100:  br_taken = ($signed(a_q) < $signed(b_q));
      3'b101:  br_taken = !($signed(a_q) < $signed(b_q));
      3'b110:  br_taken = (a_q < b_q);
      3'b111:  br_taken = !(a_q < b_q);
      default: br_taken = 1'b0;
    endcase

    is_jump = (opcode == OP_JAL) || (opcode == OP_JALR);
    tgt_d   = pc_q + 32'd4;
    if (opcode == OP_BR && br_taken) tgt_d = pc_q + imm_b;
    if (opcode == OP_JAL)            tgt_d = pc_q + imm_j;
    if (opcode == OP_JALR)           tgt_d = (a_q + imm_i) & ~32'd1;

    addr_d = a_q + ((opcode == OP_ST) ? imm_s : imm_i);
    wb_val = (opcode == OP_LD) ? mdr_q : alu_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      result_q <= '0;
      retire_q <= 1'b0;
    end else begin
      retire_q <= 1'b0;
      case (state_q)
        S_FETCH: if (mem_ready) begin
          ir_q    <= mem_rdata;
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          a_q     <= rs1_val;
          b_q     <= rs2_val;
          state_q <= (legal && !reg_bad) ? S_EXEC : S_TRAP;
        end
        S_EXEC: begin
          if (opcode == OP_BR || is_jump) begin
            if (TRAP_ON_MISALIGN && tgt_d[1]) begin
              state_q <= S_TRAP;
            end else begin
              pc_q     <= {tgt_d[31:2], 2'b00};
              retire_q <= 1'b1;
              state_q  <= S_FETCH;
              if (is_jump) begin
                if (rd != '0) rf_q[rd[RW-1:0]] <= pc_q + 32'd4;
                result_q <= pc_q + 32'd4;
              end
            end
          end else if (opcode == OP_LD || opcode == OP_ST) begin
            if (TRAP_ON_MISALIGN && addr_d[1:0] != 2'b00) begin
              state_q <= S_TRAP;
            end else begin
              alu_q   <= {addr_d[31:2], 2'b00};
              state_q <= S_MEM;
            end
          end else begin
            alu_q   <= alu_d;
            state_q <= S_WB;
          end
        end
        S_MEM: if (mem_ready) begin
          if (opcode == OP_ST) begin
            pc_q     <= pc_q + 32'd4;
            retire_q <= 1'b1;
            state_q  <= S_FETCH;
          end else begin
            mdr_q   <= mem_rdata;
            state_q <= S_WB;
          end
        end
        S_WB: begin
          if (rd != '0) rf_q[rd[RW-1:0]] <= wb_val;
          result_q <= wb_val;
          pc_q     <= pc_q + 32'd4;
          retire_q <= 1'b1;
          state_q  <= S_FETCH;
        end
        default: state_q <= S_TRAP;
      endcase
    end
  end

  // Request strobe is decoded from registered state so it can drop in the same cycle reset rises.
  assign mem_valid = !reset && (state_q == S_FETCH || state_q == S_MEM);
  assign mem_we    = mem_valid && (state_q == S_MEM) && (opcode == OP_ST);
  assign mem_addr  = (state_q == S_MEM) ? alu_q : pc_q;
  assign mem_wdata = b_q;
  assign PC        = pc_q;
  assign Result    = result_q;
  assign retire    = retire_q;
  assign halted    = (state_q == S_TRAP);
endmodule

// File: tb/tb_riscv_mc_cpu.sv
// Directed bench for riscv_mc_cpu: small program on a RAM model with a wait-stated word at 0x4,
// plus an RV32E instance for the register-range trap and reset-during-fetch behaviour.
module tb_riscv_mc_cpu;
  logic        clk, rst, rst16;
  logic        mem_valid, mem_we, mem_ready, retire, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc, result;
  logic        mv16, we16, ready16, retire16, halted16;
  logic [31:0] addr16, wdata16, rdata16, pc16, result16;

  int          total = 0;
  int          bad = 0;
  int          lat_d = 0;
  int          wcnt, wr_cycles = 0, wr_bad = 0, ret16_cnt = 0;
  bit          patch = 1'b0;
  logic [31:0] mem [64];

  riscv_mc_cpu dut (
    .clk(clk), .reset(rst), .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .PC(pc),
    .Result(result), .retire(retire), .halted(halted)
  );

  riscv_mc_cpu #(.NREGS(16)) dut16 (
    .clk(clk), .reset(rst16), .mem_valid(mv16), .mem_we(we16), .mem_addr(addr16),
    .mem_wdata(wdata16), .mem_rdata(rdata16), .mem_ready(ready16), .PC(pc16),
    .Result(result16), .retire(retire16), .halted(halted16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Only the data word at 0x4 is wait-stated; instruction fetches complete immediately.
  assign mem_ready = mem_valid && (wcnt >= ((mem_addr == 32'h4) ? lat_d : 0));
  assign mem_rdata = mem[mem_addr[7:2]];
  assign rdata16   = 32'h002088B3;  // add x17,x1,x2

  always @(posedge clk) begin
    if (rst) begin
      wcnt <= 0;
      for (int i = 0; i < 64; i++) mem[i] <= 32'h00000013;
      mem[0]  <= 32'h00500093;  // addi x1,x0,5
      mem[1]  <= 32'hFF908113;  // addi x2,x1,-7
      mem[2]  <= 32'h00202223;  // sw   x2,4(x0)
      mem[3]  <= 32'h00402183;  // lw   x3,4(x0)
      mem[4]  <= 32'hFE009CE3;  // bne  x1,x0,-8
      mem[5]  <= 32'h00C0006F;  // jal  x0,+12
      mem[8]  <= 32'h00C000EF;  // jal  x1,+12
      mem[9]  <= 32'h00602203;  // lw   x4,6(x0)
      mem[11] <= 32'h00108067;  // jalr x0,1(x1)
    end else begin
      wcnt <= (mem_valid && !mem_ready) ? wcnt + 1 : 0;
      if (mem_valid && mem_we && mem_ready) mem[mem_addr[7:2]] <= mem_wdata;
      if (patch) mem[4] <= 32'hFE008CE3;  // beq x1,x0,-8
    end
  end

  always @(negedge clk) begin
    if (mem_valid && mem_we) begin
      wr_cycles++;
      if (mem_addr != 32'h4 || mem_wdata != 32'hFFFF_FFFE) wr_bad++;
    end
    if (retire16) ret16_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_ret(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!retire && n < 40);
  endtask

  initial begin
    int n, mv_seen, ret_seen;
    rst = 1'b1; rst16 = 1'b1; ready16 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", {31'b0, mem_valid}, 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_retire", {31'b0, retire}, 32'd0);
    check("rst_halted", {31'b0, halted}, 32'd0);
    check("rst_result", result, 32'h0);
    check("rst16_valid", {31'b0, mv16}, 32'd0);
    rst = 1'b0;

    wait_ret(n); check("addi1_cyc", n, 4); check("addi1_pc", pc, 32'h4); check("addi1_res", result, 32'd5);
    wait_ret(n); check("addi2_cyc", n, 4); check("addi2_pc", pc, 32'h8);
    check("addi2_res", result, 32'hFFFF_FFFE);

    lat_d = 2;
    wait_ret(n); check("sw_cyc", n, 6); check("sw_pc", pc, 32'hC);
    check("sw_req_cycles", wr_cycles, 3); check("sw_req_bad", wr_bad, 0);
    wait_ret(n); check("lw_cyc", n, 7); check("lw_pc", pc, 32'h10);
    check("lw_res", result, 32'hFFFF_FFFE);
    wait_ret(n); check("bne_cyc", n, 3); check("bne_pc", pc, 32'h8);

    patch = 1'b1;
    wait_ret(n); check("sw2_cyc", n, 6);
    wait_ret(n); check("lw2_cyc", n, 7);
    wait_ret(n); check("beq_cyc", n, 3); check("beq_pc", pc, 32'h14);
    wait_ret(n); check("jal0_pc", pc, 32'h20);
    wait_ret(n); check("jal1_cyc", n, 3); check("jal1_pc", pc, 32'h2C);
    wait_ret(n); check("jalr_cyc", n, 3); check("jalr_pc", pc, 32'h24);

    repeat (3) @(negedge clk);
    check("mis_halted", {31'b0, halted}, 32'd1);
    mv_seen = 0; ret_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (mem_valid) mv_seen++;
      if (retire) ret_seen++;
    end
    check("mis_no_valid", mv_seen, 0);
    check("mis_no_retire", ret_seen, 0);
    check("mis_pc", pc, 32'h24);
    rst = 1'b1;
    @(negedge clk);
    check("rerst_pc", pc, 32'h0);
    check("rerst_halted", {31'b0, halted}, 32'd0);

    rst16 = 1'b0;
    repeat (2) @(negedge clk);
    check("f16_valid", {31'b0, mv16}, 32'd1);
    check("f16_addr", addr16, 32'h0);
    rst16 = 1'b1;
    #1;
    check("f16_rst_drop", {31'b0, mv16}, 32'd0);
    @(negedge clk);
    ready16 = 1'b1;
    rst16 = 1'b0;
    repeat (2) @(negedge clk);
    check("rv32e_trap", {31'b0, halted16}, 32'd1);
    check("rv32e_pc", pc16, 32'h0);
    check("rv32e_no_retire", ret16_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
